// File: rtl/debug_burst_arbiter.sv
// Round-robin arbiter that packs one debug source at a time into fixed-length
// frames (header, payload, trailer) written into a downstream FIFO.
module debug_burst_arbiter #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned BURST_LEN  = 1024,
   parameter int unsigned FIFO_DEPTH = 4096
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_SRC-1:0]     src_req,
   input  logic [32*NUM_SRC-1:0]  src_data,
   output logic [NUM_SRC-1:0]     src_grant,
   output logic [NUM_SRC-1:0]     src_done,
   input  logic [12:0]            fifo_wrusedw,
   output logic                   fifo_wrreq,
   output logic [31:0]            fifo_data,
   output logic [15:0]            frame_seq
);

   localparam int unsigned   CW        = $clog2(BURST_LEN);
   localparam logic [CW-1:0] LAST_PAY  = CW'(BURST_LEN - 3);
   localparam logic [13:0]   START_MAX = 14'(FIFO_DEPTH - BURST_LEN);
   localparam logic [2:0]    NSRC3     = 3'(NUM_SRC);
   localparam logic [1:0]    LAST_SRC  = 2'(NUM_SRC - 1);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;

   state_t             state_q, state_d;
   logic [1:0]         winner_q, winner_d;
   logic [1:0]         rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic [NUM_SRC-1:0] done_q, done_d;
   logic               wrreq_q, wrreq_d;
   logic [31:0]        data_q, data_d;
   logic [15:0]        frame_seq_q, frame_seq_d;

   logic [1:0]         pick;
   logic               pick_vld;
   logic [2:0]         rr_sum;
   logic [31:0]        sel_data;

   // First requester found scanning upward from rr_ptr, wrapping at NUM_SRC.
   always_comb begin
      pick     = rr_ptr_q;
      pick_vld = 1'b0;
      rr_sum   = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         rr_sum = {1'b0, rr_ptr_q} + 3'(k);
         if (rr_sum >= NSRC3) rr_sum = rr_sum - NSRC3;
         if (!pick_vld && src_req[rr_sum[1:0]]) begin
            pick_vld = 1'b1;
            pick     = rr_sum[1:0];
         end
      end
   end

   assign sel_data = 32'(src_data >> (32 * winner_q));

   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      done_d      = '0;
      wrreq_d     = wrreq_q;
      data_d      = data_q;
      frame_seq_d = frame_seq_q;
      unique case (state_q)
         IDLE: begin
            wrreq_d = 1'b0;
            grant_d = '0;
            if (enable && pick_vld && ({1'b0, fifo_wrusedw} <= START_MAX)) begin
               state_d  = HEADER;
               winner_d = pick;
               grant_d  = NUM_SRC'(1) << pick;
               wrreq_d  = 1'b1;
               data_d   = {8'hA5, 6'b0, pick, frame_seq_q};
            end
         end
         HEADER: begin
            state_d = PAYLOAD;
            cnt_d   = '0;
            data_d  = sel_data;
         end
         PAYLOAD: begin
            if (cnt_q == LAST_PAY) begin
               state_d = TRAILER;
               data_d  = 32'hFFFF_FFFF;
               done_d  = grant_q;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               data_d = sel_data;
            end
         end
         TRAILER: begin
            state_d     = IDLE;
            wrreq_d     = 1'b0;
            grant_d     = '0;
            cnt_d       = '0;
            frame_seq_d = frame_seq_q + 16'd1;
            rr_ptr_d    = (winner_q == LAST_SRC) ? 2'd0 : winner_q + 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         winner_q    <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         wrreq_q     <= 1'b0;
         data_q      <= '0;
         frame_seq_q <= '0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         wrreq_q     <= wrreq_d;
         data_q      <= data_d;
         frame_seq_q <= frame_seq_d;
      end
   end

   assign src_grant  = grant_q;
   assign src_done   = done_q;
   assign fifo_wrreq = wrreq_q;
   assign fifo_data  = data_q;
   assign frame_seq  = frame_seq_q;

endmodule

// File: tb/tb_debug_burst_arbiter.sv
// Bench for debug_burst_arbiter: word-position frame model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_debug_burst_arbiter;

   localparam int NS = 4;
   localparam int BL = 1024;
   localparam int FD = 4096;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [3:0]    src_req = '0;
   logic [127:0]  src_data = '0;
   logic [12:0]   fifo_wrusedw = '0;
   logic [3:0]    src_grant;
   logic [3:0]    src_done;
   logic          fifo_wrreq;
   logic [31:0]   fifo_data;
   logic [15:0]   frame_seq;

   debug_burst_arbiter #(.NUM_SRC(NS), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .enable(enable), .src_req(src_req),
      .src_data(src_data), .src_grant(src_grant), .src_done(src_done),
      .fifo_wrusedw(fifo_wrusedw), .fifo_wrreq(fifo_wrreq),
      .fifo_data(fifo_data), .frame_seq(frame_seq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;
   bit preload = 1'b0;
   int cyc = 0;

   // Frame model: busy flag plus word position inside the frame.
   bit          m_busy, n_busy;
   int          m_pos, n_pos, m_src, n_src, m_ptr, n_ptr;
   logic [15:0] m_seq, n_seq;
   logic        m_wrreq, n_wrreq;
   logic [31:0] m_data, n_data;
   logic [3:0]  m_grant, n_grant, m_done, n_done;
   bit          found;

   always_comb begin
      n_busy  = m_busy;
      n_pos   = m_pos;
      n_src   = m_src;
      n_ptr   = m_ptr;
      n_seq   = preload ? 16'hFFFF : m_seq;
      n_wrreq = m_wrreq;
      n_data  = m_data;
      n_grant = m_grant;
      n_done  = '0;
      found   = 1'b0;
      if (!m_busy) begin
         n_wrreq = 1'b0;
         n_grant = '0;
         if (enable && src_req != 0 && fifo_wrusedw <= 13'(FD - BL)) begin
            for (int k = 0; k < NS; k++)
               if (!found && src_req[2'((m_ptr + k) % NS)]) begin
                  found = 1'b1;
                  n_src = (m_ptr + k) % NS;
               end
            n_busy  = 1'b1;
            n_pos   = 0;
            n_wrreq = 1'b1;
            n_grant = 4'(1 << n_src);
            n_data  = {8'hA5, 6'b0, 2'(n_src), n_seq};
         end
      end else if (m_pos == BL - 1) begin
         n_busy  = 1'b0;
         n_wrreq = 1'b0;
         n_grant = '0;
         n_seq   = n_seq + 16'd1;
         n_ptr   = (m_src + 1) % NS;
      end else begin
         n_pos = m_pos + 1;
         if (n_pos == BL - 1) begin
            n_data = 32'hFFFF_FFFF;
            n_done = m_grant;
         end else begin
            n_data = 32'(src_data >> (32 * m_src));
         end
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0; m_pos <= 0; m_src <= 0; m_ptr <= 0; m_seq <= '0;
         m_wrreq <= 1'b0; m_data <= '0; m_grant <= '0; m_done <= '0;
      end else begin
         m_busy <= n_busy; m_pos <= n_pos; m_src <= n_src; m_ptr <= n_ptr;
         m_seq <= n_seq; m_wrreq <= n_wrreq; m_data <= n_data;
         m_grant <= n_grant; m_done <= n_done;
      end
   end

   // Each source presents {index+1, cycle count}, so consecutive payload words step by one.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < NS; i++) src_data[32*i +: 32] = {8'(i + 1), 24'(cyc)};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic capture(input bit clear_req, input bit disturb,
                          output logic [31:0] hdr, output int n, output logic [31:0] last,
                          output logic [3:0] g, output int donecnt, output bit incr_ok,
                          output logic [31:0] p1);
      int w;
      logic [31:0] prev;
      w = 0; n = 0; donecnt = 0; incr_ok = 1'b1; prev = '0; last = '0; p1 = '0;
      while (fifo_wrreq !== 1'b1 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      chk("frame_start_timeout", 32'(fifo_wrreq), 32'd1);
      hdr = fifo_data;
      g   = src_grant;
      if (clear_req) src_req = '0;
      while (fifo_wrreq === 1'b1 && n < 1100) begin
         if (n >= 2 && n <= BL - 2 && fifo_data !== prev + 32'd1) incr_ok = 1'b0;
         if (n == 1) p1 = fifo_data;
         if (src_done !== '0) donecnt++;
         if (disturb && n == 500) begin
            src_req = '0; enable = 1'b0; fifo_wrusedw = 13'd4000;
         end
         prev = fifo_data;
         last = fifo_data;
         n++;
         @(negedge clk);
      end
   endtask

   logic [31:0] exp_hdr [5] = '{32'hA500_0000, 32'hA501_0001, 32'hA502_0002,
                                32'hA503_0003, 32'hA500_0004};
   logic [3:0]  exp_g   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   initial begin
      logic [31:0] hdr, last, p1;
      int n, dc, hi, w;
      logic [3:0] g;
      bit inc;

      fork
         forever begin
            @(negedge clk);
            if (cmp_en) begin
               checks++;
               if ({fifo_wrreq, fifo_data, src_grant, src_done, frame_seq} !==
                   {m_wrreq, m_data, m_grant, m_done, m_seq}) begin
                  errors++;
                  $display("FAIL model t=%0t: wrreq=%b data=%h grant=%b done=%b seq=%h required wrreq=%b data=%h grant=%b done=%b seq=%h",
                           $time, fifo_wrreq, fifo_data, src_grant, src_done, frame_seq,
                           m_wrreq, m_data, m_grant, m_done, m_seq);
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
      chk("rst_data", fifo_data, 32'd0);
      chk("rst_grant", 32'(src_grant), 32'd0);
      chk("rst_done", 32'(src_done), 32'd0);
      chk("rst_seq", 32'(frame_seq), 32'd0);
      cmp_en = 1'b1;

      // Single source frame
      reset = 1'b1; src_req = 4'b0001; enable = 1'b1; fifo_wrusedw = '0;
      capture(1'b1, 1'b0, hdr, n, last, g, dc, inc, p1);
      chk("single_hdr", hdr, 32'hA500_0000);
      chk("single_len", 32'(n), 32'd1024);
      chk("single_trailer", last, 32'hFFFF_FFFF);
      chk("single_grant", 32'(g), 32'd1);
      chk("single_done_pulses", 32'(dc), 32'd1);
      chk("single_payload_step", 32'(inc), 32'd1);
      chk("single_payload_src", 32'(p1[31:24]), 32'h01);
      chk("single_seq_after", 32'(frame_seq), 32'd1);

      // Round robin over five back-to-back frames from a fresh reset
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1; src_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         capture(k == 4, 1'b0, hdr, n, last, g, dc, inc, p1);
         chk($sformatf("rr_hdr%0d", k), hdr, exp_hdr[k]);
         chk($sformatf("rr_grant%0d", k), 32'(g), 32'(exp_g[k]));
         chk($sformatf("rr_len%0d", k), 32'(n), 32'd1024);
      end

      // Start threshold: 3073 blocks, 3072 starts
      fifo_wrusedw = 13'd3073; src_req = 4'b0001;
      hi = 0;
      repeat (100) begin
         @(negedge clk);
         if (fifo_wrreq) hi++;
      end
      chk("thresh_hold", 32'(hi), 32'd0);
      fifo_wrusedw = 13'd3072;
      @(negedge clk);
      chk("thresh_start", 32'(fifo_wrreq), 32'd1);
      capture(1'b1, 1'b0, hdr, n, last, g, dc, inc, p1);
      chk("thresh_hdr", hdr, 32'hA500_0005);
      chk("thresh_len", 32'(n), 32'd1024);
      fifo_wrusedw = '0;

      // Disturbance mid-frame must not cut the frame short
      src_req = 4'b0010;
      capture(1'b0, 1'b1, hdr, n, last, g, dc, inc, p1);
      chk("disturb_hdr", hdr, 32'hA501_0006);
      chk("disturb_len", 32'(n), 32'd1024);
      chk("disturb_trailer", last, 32'hFFFF_FFFF);
      chk("disturb_payload_src", 32'(p1[31:24]), 32'h02);
      hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_wrreq) hi++;
      end
      chk("disturb_idle", 32'(hi), 32'd0);
      enable = 1'b1; fifo_wrusedw = '0;

      // Asynchronous reset in the middle of a payload
      src_req = 4'b0001;
      w = 0;
      while (fifo_wrreq !== 1'b1 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      chk("rstmid_start", 32'(fifo_wrreq), 32'd1);
      repeat (300) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rstmid_wrreq", 32'(fifo_wrreq), 32'd0);
      chk("rstmid_grant", 32'(src_grant), 32'd0);
      chk("rstmid_data", fifo_data, 32'd0);
      src_req = 4'b0100;
      @(negedge clk);
      reset = 1'b1;
      capture(1'b1, 1'b0, hdr, n, last, g, dc, inc, p1);
      chk("rstmid_next_hdr", hdr, 32'hA502_0000);
      chk("rstmid_next_len", 32'(n), 32'd1024);

      // Sequence number wrap
      cmp_en = 1'b0;
      preload = 1'b1;
      force dut.frame_seq_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.frame_seq_q;
      preload = 1'b0;
      cmp_en = 1'b1;
      src_req = 4'b0001;
      capture(1'b0, 1'b0, hdr, n, last, g, dc, inc, p1);
      chk("wrap_hdr_ffff", hdr, 32'hA500_FFFF);
      chk("wrap_seq_after", 32'(frame_seq), 32'd0);
      capture(1'b1, 1'b0, hdr, n, last, g, dc, inc, p1);
      chk("wrap_hdr_0000", hdr, 32'hA500_0000);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
